// File: rtl/puf_sequencer.sv
// puf_sequencer: multi-bit challenge/response controller for a 1-bit
// ring-oscillator PUF core. Measures one challenge bit per pass
// (CLEAR -> MEASURE -> SETTLE -> CAPTURE) and assembles the response LSB first.
// Optional build macro PUF_MAJORITY_VOTE_EN: each bit is measured three times
// and the response bit is the majority of the three samples.
module puf_sequencer #(
    parameter int RESP_BITS     = 8,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [RESP_BITS-1:0] challenge_in,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response_out,
    output logic                 puf_start,
    output logic                 puf_challenge,
    input  logic                 puf_response
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int WIN_W = $clog2(WINDOW_CYCLES) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MEASURE, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [RESP_BITS-1:0] chal;
    logic [IDX_W-1:0]     idx;
    logic [WIN_W-1:0]     win_cnt;
    logic [SET_W-1:0]     set_cnt;
    logic                 last_bit;
    logic                 vote_last;
    logic                 bit_value;

    assign last_bit = (idx == IDX_LAST);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] vote_cnt;
    logic [1:0] samples;

    // Third pass of a bit closes the vote; majority of two stored samples plus the live one.
    assign vote_last = (vote_cnt == 2'd2);
    assign bit_value = (samples[0] & samples[1]) | (samples[0] & puf_response) |
                       (samples[1] & puf_response);

    // Vote bookkeeping: count passes per bit and keep the first two samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_cnt <= '0;
            samples  <= '0;
        end else if (state == S_IDLE && req) begin
            vote_cnt <= '0;
        end else if (state == S_CAPTURE) begin
            if (vote_last) begin
                vote_cnt <= '0;
            end else begin
                samples[vote_cnt[0]] <= puf_response;
                vote_cnt             <= vote_cnt + 1'b1;
            end
        end
    end
`else
    assign vote_last = 1'b1;
    assign bit_value = puf_response;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nxt     = state;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        puf_start     = (state == S_CLEAR);
        // Latched challenge copy keeps the mux select steady for the whole pass.
        puf_challenge = 1'b0;
        if (state == S_CLEAR || state == S_MEASURE || state == S_SETTLE || state == S_CAPTURE)
            puf_challenge = chal[idx];
        case (state)
            S_IDLE:    if (req) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_MEASURE;
            S_MEASURE: if (win_cnt == WIN_LAST) state_nxt = S_SETTLE;
            S_SETTLE:  if (set_cnt == SET_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (vote_last && last_bit) ? S_DONE : S_CLEAR;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Datapath: challenge latch, bit index, window/settle timers, response assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal         <= '0;
            idx          <= '0;
            win_cnt      <= '0;
            set_cnt      <= '0;
            response_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        chal <= challenge_in;
                        idx  <= '0;
                    end
                end
                S_MEASURE: win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
                S_SETTLE:  set_cnt <= (set_cnt == SET_LAST) ? '0 : set_cnt + 1'b1;
                S_CAPTURE: begin
                    // Only the final pass of a bit writes; earlier bits stay, later bits keep old values.
                    if (vote_last) begin
                        response_out[idx] <= bit_value;
                        if (!last_bit) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
